dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_pkg.sv | 15 +
 rtl/dmem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

    // Access sequencer states: IDLE -> REQ -> (WAIT) -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    // Default bound on cycles spent in REQ+WAIT before an access is abandoned
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store sequencer for a variable-latency data-memory bus.
// Holds the F/D/E/M registers while an access is outstanding and bubbles
// MEM/WB so each memory instruction reaches WriteBack exactly once.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallM,
    output logic              FlushW,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              ErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    dmem_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic access;
    logic timeout_hit;

    // A read wins when both strobes are set, so access alone decides start.
    assign access      = MemReadM | MemWriteM;
    assign timeout_hit = (cnt_q == CNT_LIMIT);

    // Stall while an access is starting or outstanding; DONE releases the pipe.
    assign StallM = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT);
    assign FlushW = StallM;

    assign ReadDataM = rdata_q;
    assign ErrM      = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Access FSM with registered bus outputs, timeout counter and load capture.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        addr_q  <= ALUResultM;
                        wdata_q <= WriteDataM;
                        we_q    <= MemWriteM & ~MemReadM;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // Abort takes priority so the stall is strictly bounded.
                    if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (mem_gnt && mem_rvalid) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= DONE;
                    end else if (mem_rvalid) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: reset, loads, stores, timeout and
// back-to-back behaviour against hand-computed stall counts and data.
module tb_dmem_access_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              MemReadM = 1'b0;
    logic              MemWriteM = 1'b0;
    logic [ADDR_W-1:0] ALUResultM = '0;
    logic [DATA_W-1:0] WriteDataM = '0;
    logic              StallM;
    logic              FlushW;
    logic [DATA_W-1:0] ReadDataM;
    logic              ErrM;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          stalls;
        int          req_cycles;
        bit          saw_wait;
        logic [31:0] done_rdata;
        logic        done_req;
        logic        done_err;
        bit          timed_out;
        int          flush_bad;
        int          bus_bad;
        logic        first_req;
        dmem_state_e first_state;
    } acc_res_t;

    dmem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .StallM    (StallM),
        .FlushW    (FlushW),
        .ReadDataM (ReadDataM),
        .ErrM      (ErrM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one memory instruction and act as the bus slave: grant after
    // gnt_wait un-granted REQ cycles, respond rv_wait cycles into WAIT
    // (rv_wait<0 means rvalid together with gnt). Returns at the DONE cycle.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_wait, input int rv_wait,
                             input logic [31:0] rdata, output acc_res_t r);
        int   req_n;
        int   wait_n;
        bit   granted;
        bit   done;
        logic exp_we;
        r.stalls = 0; r.req_cycles = 0; r.saw_wait = 0; r.done_rdata = '0;
        r.done_req = 1'b0; r.done_err = 1'b0; r.timed_out = 0; r.flush_bad = 0;
        r.bus_bad = 0; r.first_req = 1'b0; r.first_state = IDLE;
        exp_we  = wr & ~rd;
        req_n   = 0;
        wait_n  = 0;
        granted = 0;
        done    = 0;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req) begin
                if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== exp_we) r.bus_bad++;
                if (req_n == gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (rv_wait < 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = rdata;
                    end
                end
                req_n++;
            end else if (granted) begin
                if (wait_n == rv_wait) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rdata;
                end
                wait_n++;
            end
            #1;
            if (c == 0) begin
                r.first_req = mem_req;
                r.first_state = dut.state_q;
            end
            if (FlushW !== StallM) r.flush_bad++;
            if (dut.state_q == WAIT) r.saw_wait = 1;
            if (StallM) begin
                r.stalls++;
            end else begin
                done = 1;
                r.done_rdata = ReadDataM;
                r.done_req = mem_req;
                r.done_err = ErrM;
            end
            if (mem_gnt && !mem_rvalid) granted = 1;
        end
        r.req_cycles = req_n;
        r.timed_out = !done;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        acc_res_t r;
        acc_res_t r2;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", dut.state_q, IDLE);
        check("rst_req", mem_req, 0);
        check("rst_rdata", ReadDataM, 0);
        check("rst_err", ErrM, 0);
        check("rst_stall", StallM, 0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait load
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, 32'hCAFE_F00D, r);
        check("ld0_done", r.timed_out, 0);
        check("ld0_stalls", r.stalls, 3);
        check("ld0_rdata", r.done_rdata, 32'hCAFE_F00D);
        check("ld0_flush", r.flush_bad, 0);
        check("ld0_bus", r.bus_bad, 0);
        check("ld0_done_req", r.done_req, 0);
        check("ld0_first_req", r.first_req, 0);

        // Slow store: gnt on 5th REQ cycle, rvalid on 2nd WAIT cycle
        do_access(1'b0, 1'b1, 32'h200, 32'h1234, 4, 1, 32'hDEAD_0000, r);
        check("st_done", r.timed_out, 0);
        check("st_stalls", r.stalls, 8);
        check("st_req_cycles", r.req_cycles, 5);
        check("st_bus", r.bus_bad, 0);
        check("st_rdata_kept", r.done_rdata, 32'hCAFE_F00D);
        check("st_flush", r.flush_bad, 0);

        // Same-cycle gnt+rvalid read
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 0, -1, 32'h5A5A_1234, r);
        check("sc_stalls", r.stalls, 2);
        check("sc_rdata", r.done_rdata, 32'h5A5A_1234);
        check("sc_no_wait", r.saw_wait, 0);

        // Both strobes set behaves as a read
        do_access(1'b1, 1'b1, 32'h310, 32'h77, 0, 0, 32'h0F0F_0F0F, r);
        check("rw_bus", r.bus_bad, 0);
        check("rw_rdata", r.done_rdata, 32'h0F0F_0F0F);

        // Back-to-back loads
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 32'h1111_0001, r);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 1, 0, 32'h2222_0002, r2);
        check("bb0_rdata", r.done_rdata, 32'h1111_0001);
        check("bb1_first_state", r2.first_state, IDLE);
        check("bb1_first_req", r2.first_req, 0);
        check("bb1_req_cycles", r2.req_cycles, 2);
        check("bb1_stalls", r2.stalls, 4);
        check("bb1_rdata", r2.done_rdata, 32'h2222_0002);
        check("bb1_bus", r2.bus_bad, 0);

        // Non-memory instruction: no stall, no bus activity
        @(negedge clk);
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h999;
        #1;
        check("nm_stall", StallM, 0);
        check("nm_flush", FlushW, 0);
        @(negedge clk);
        #1;
        check("nm_req", mem_req, 0);
        check("nm_state", dut.state_q, IDLE);

        // Timeout: never granted; 8 counted REQ cycles then abort on the 9th
        do_access(1'b1, 1'b0, 32'h400, 32'h0, 1000, 0, 32'hFFFF_FFFF, r);
        check("to_done", r.timed_out, 0);
        check("to_stalls", r.stalls, 10);
        check("to_err", r.done_err, 1);
        check("to_rdata", r.done_rdata, 0);
        check("to_done_req", r.done_req, 0);

        // ErrM stays set through a later good access
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 32'h0BAD_BEEF, r);
        check("err_sticky", r.done_err, 1);
        check("post_to_rdata", r.done_rdata, 32'h0BAD_BEEF);

        // Reset in the middle of WAIT
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h80;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rdata = 32'hAAAA_5555;
        #1;
        check("mid_state", dut.state_q, WAIT);
        rst = 1'b1;
        MemReadM = 1'b0;
        #1;
        check("mrst_state", dut.state_q, IDLE);
        check("mrst_rdata", ReadDataM, 0);
        check("mrst_err", ErrM, 0);
        check("mrst_req", mem_req, 0);
        check("mrst_addr", mem_addr, 0);
        check("mrst_stall", StallM, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        #1;
        check("late_rv_rdata", ReadDataM, 0);
        check("late_rv_stall", StallM, 0);
        check("late_rv_state", dut.state_q, IDLE);
        mem_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
